// File: rtl/data_mem_arbiter.sv
// Shares the single data RAM port between the pipeline MEM stage and a debug/loader port.
// Pipeline has priority; a saturating defer counter forces a debug grant after MAX_DEFER pipe grants.
module data_mem_arbiter #(
  parameter int unsigned WAIT_STATES = 1,
  parameter int unsigned MAX_DEFER   = 4
) (
  input  logic        CLK,
  input  logic        CLR,
  input  logic        pipe_req,
  input  logic        pipe_rw,
  input  logic [1:0]  pipe_size,
  input  logic [7:0]  pipe_addr,
  input  logic [31:0] pipe_wdata,
  output logic [31:0] pipe_rdata,
  output logic        pipe_stall,
  input  logic        dbg_req,
  input  logic        dbg_rw,
  input  logic [1:0]  dbg_size,
  input  logic [7:0]  dbg_addr,
  input  logic [31:0] dbg_wdata,
  output logic        dbg_ack,
  output logic [31:0] dbg_rdata,
  output logic        mem_enable,
  output logic        mem_rw,
  output logic [1:0]  mem_size,
  output logic [7:0]  mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0] DEFER_MAX = CNT_W'(MAX_DEFER);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;

  typedef struct packed {
    logic        rw;
    logic [1:0]  size;
    logic [7:0]  addr;
    logic [31:0] wdata;
  } mem_req_t;

  state_t           state;
  logic             owner_dbg;
  mem_req_t         req_q;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] defer_cnt;
  logic             grant_dbg_c;
  mem_req_t         sel_req_c;
  logic             in_access_c;

  // Pipe wins a tie unless debug has already been deferred MAX_DEFER times
  always_comb begin
    grant_dbg_c = dbg_req && (!pipe_req || (defer_cnt == DEFER_MAX));
    sel_req_c   = grant_dbg_c ? {dbg_rw, dbg_size, dbg_addr, dbg_wdata}
                              : {pipe_rw, pipe_size, pipe_addr, pipe_wdata};
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      state      <= S_IDLE;
      owner_dbg  <= 1'b0;
      req_q      <= '0;
      wait_cnt   <= '0;
      defer_cnt  <= '0;
      pipe_rdata <= '0;
      dbg_rdata  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pipe_req || dbg_req) begin
            owner_dbg <= grant_dbg_c;
            req_q     <= sel_req_c;
            wait_cnt  <= WAIT_INIT;
            state     <= S_ACCESS;
            if (grant_dbg_c) begin
              defer_cnt <= '0;
            end else if (dbg_req && (defer_cnt != DEFER_MAX)) begin
              defer_cnt <= defer_cnt + CNT_W'(1);
            end
          end
        end
        S_ACCESS: begin
          if (wait_cnt != '0) begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end else begin
            // Strobe cycle: reads land in the owner's data register, writes leave both untouched
            if (!req_q.rw) begin
              if (owner_dbg) dbg_rdata  <= mem_rdata;
              else           pipe_rdata <= mem_rdata;
            end
            state <= S_DONE;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Memory port is driven only while an access is in flight; strobe fires once per access
  always_comb begin
    in_access_c = (state == S_ACCESS);
    mem_enable  = in_access_c && (wait_cnt == '0);
    mem_rw      = in_access_c && req_q.rw;
    mem_size    = in_access_c ? req_q.size  : '0;
    mem_addr    = in_access_c ? req_q.addr  : '0;
    mem_wdata   = in_access_c ? req_q.wdata : '0;
    dbg_ack     = (state == S_DONE) && owner_dbg;
    pipe_stall  = pipe_req && !((state == S_DONE) && !owner_dbg);
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Self-checking bench for data_mem_arbiter: WAIT_STATES=1 main instance, WAIT_STATES=0 instance for back-to-back.
// Byte-addressed RAM models sit behind each instance; a reference memory and queue hold expected read data.
module tb_data_mem_arbiter;

  logic clk = 1'b0;
  logic rst_n, rst0_n;
  always #5 clk = ~clk;

  logic        p_req, p_rw, p_stall, d_req, d_rw, d_ack, m_en, m_rw;
  logic [1:0]  p_size, d_size, m_size;
  logic [7:0]  p_addr, d_addr, m_addr;
  logic [31:0] p_wdata, p_rdata, d_wdata, d_rdata, m_wdata, m_rdata;

  logic        p0_req, p0_rw, p0_stall, d0_req, d0_rw, d0_ack, m0_en, m0_rw;
  logic [1:0]  p0_size, d0_size, m0_size;
  logic [7:0]  p0_addr, d0_addr, m0_addr;
  logic [31:0] p0_wdata, p0_rdata, d0_wdata, d0_rdata, m0_wdata, m0_rdata;

  data_mem_arbiter #(.WAIT_STATES(1), .MAX_DEFER(4)) u_dut (
    .CLK(clk), .CLR(rst_n),
    .pipe_req(p_req), .pipe_rw(p_rw), .pipe_size(p_size), .pipe_addr(p_addr),
    .pipe_wdata(p_wdata), .pipe_rdata(p_rdata), .pipe_stall(p_stall),
    .dbg_req(d_req), .dbg_rw(d_rw), .dbg_size(d_size), .dbg_addr(d_addr),
    .dbg_wdata(d_wdata), .dbg_ack(d_ack), .dbg_rdata(d_rdata),
    .mem_enable(m_en), .mem_rw(m_rw), .mem_size(m_size), .mem_addr(m_addr),
    .mem_wdata(m_wdata), .mem_rdata(m_rdata)
  );

  data_mem_arbiter #(.WAIT_STATES(0), .MAX_DEFER(4)) u_dut0 (
    .CLK(clk), .CLR(rst0_n),
    .pipe_req(p0_req), .pipe_rw(p0_rw), .pipe_size(p0_size), .pipe_addr(p0_addr),
    .pipe_wdata(p0_wdata), .pipe_rdata(p0_rdata), .pipe_stall(p0_stall),
    .dbg_req(d0_req), .dbg_rw(d0_rw), .dbg_size(d0_size), .dbg_addr(d0_addr),
    .dbg_wdata(d0_wdata), .dbg_ack(d0_ack), .dbg_rdata(d0_rdata),
    .mem_enable(m0_en), .mem_rw(m0_rw), .mem_size(m0_size), .mem_addr(m0_addr),
    .mem_wdata(m0_wdata), .mem_rdata(m0_rdata)
  );

  function automatic logic [31:0] size_ext(input logic [1:0] sz, input logic [31:0] w);
    case (sz)
      2'b00:   return {24'd0, w[7:0]};
      2'b01:   return {16'd0, w[15:0]};
      default: return w;
    endcase
  endfunction

  // RAM models: combinational little-endian read, write on the strobe edge
  logic [7:0] ram  [256];
  logic [7:0] ram0 [256];
  int en_cnt = 0;
  int en0_cnt = 0;

  always_comb m_rdata = size_ext(m_size, {ram[m_addr+8'd3], ram[m_addr+8'd2], ram[m_addr+8'd1], ram[m_addr]});
  always_comb m0_rdata = size_ext(m0_size, {ram0[m0_addr+8'd3], ram0[m0_addr+8'd2], ram0[m0_addr+8'd1], ram0[m0_addr]});

  always @(posedge clk) begin
    if (m_en) en_cnt <= en_cnt + 1;
    if (m_en && m_rw) begin
      ram[m_addr] <= m_wdata[7:0];
      if (m_size != 2'b00) ram[m_addr+8'd1] <= m_wdata[15:8];
      if (m_size == 2'b10) begin
        ram[m_addr+8'd2] <= m_wdata[23:16];
        ram[m_addr+8'd3] <= m_wdata[31:24];
      end
    end
  end

  always @(posedge clk) begin
    if (m0_en) en0_cnt <= en0_cnt + 1;
    if (m0_en && m0_rw) begin
      ram0[m0_addr] <= m0_wdata[7:0];
      if (m0_size != 2'b00) ram0[m0_addr+8'd1] <= m0_wdata[15:8];
      if (m0_size == 2'b10) begin
        ram0[m0_addr+8'd2] <= m0_wdata[23:16];
        ram0[m0_addr+8'd3] <= m0_wdata[31:24];
      end
    end
  end

  // Reference memory and expected-read queue
  logic [7:0]  ref_mem [256];
  logic [31:0] exp_q [$];
  int n_cmp = 0;
  int n_err = 0;

  function automatic logic [31:0] ref_read(input logic [1:0] sz, input logic [7:0] a);
    return size_ext(sz, {ref_mem[a+8'd3], ref_mem[a+8'd2], ref_mem[a+8'd1], ref_mem[a]});
  endfunction

  task automatic ref_write(input logic [1:0] sz, input logic [7:0] a, input logic [31:0] wd);
    ref_mem[a] = wd[7:0];
    if (sz != 2'b00) ref_mem[a+8'd1] = wd[15:8];
    if (sz == 2'b10) begin
      ref_mem[a+8'd2] = wd[23:16];
      ref_mem[a+8'd3] = wd[31:24];
    end
  endtask

  // Drivers: raise a request, wait (bounded) for completion, release
  task automatic pipe_go(input logic rw, input logic [1:0] sz, input logic [7:0] a, input logic [31:0] wd,
                         output int stalls, output logic [31:0] rd);
    stalls = 0;
    rd = '0;
    @(posedge clk); #1;
    p_req = 1'b1; p_rw = rw; p_size = sz; p_addr = a; p_wdata = wd;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (p_stall) stalls++;
      else begin
        rd = p_rdata;
        break;
      end
    end
    @(posedge clk); #1;
    p_req = 1'b0;
  endtask

  task automatic dbg_go(input logic rw, input logic [1:0] sz, input logic [7:0] a, input logic [31:0] wd,
                        output int ack_cyc, output logic [31:0] rd);
    ack_cyc = -1;
    rd = '0;
    @(posedge clk); #1;
    d_req = 1'b1; d_rw = rw; d_size = sz; d_addr = a; d_wdata = wd;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (d_ack) begin
        ack_cyc = i;
        rd = d_rdata;
        break;
      end
    end
    @(posedge clk); #1;
    d_req = 1'b0;
  endtask

  task automatic dbg0_go(input logic [7:0] a, input logic [31:0] wd, output int ack_cyc);
    ack_cyc = -1;
    @(posedge clk); #1;
    d0_req = 1'b1; d0_rw = 1'b1; d0_size = 2'b10; d0_addr = a; d0_wdata = wd;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (d0_ack) begin
        ack_cyc = i;
        break;
      end
    end
    @(posedge clk); #1;
    d0_req = 1'b0;
  endtask

  task automatic test_reset;
    {p_req, p_rw, p_size, p_addr, p_wdata, d_req, d_rw, d_size, d_addr, d_wdata} = '0;
    {p0_req, p0_rw, p0_size, p0_addr, p0_wdata, d0_req, d0_rw, d0_size, d0_addr, d0_wdata} = '0;
    rst_n = 1'b0;
    rst0_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if ({m_en, m_rw, m_size, m_addr, m_wdata, d_ack, p_stall} !== '0) begin
      n_err++;
      $display("FAIL reset_ctrl: got %h expected 0", {m_en, m_rw, m_size, m_addr, m_wdata, d_ack, p_stall});
    end
    n_cmp++;
    if ({p_rdata, d_rdata} !== 64'd0) begin
      n_err++;
      $display("FAIL reset_rdata: got %h expected 0", {p_rdata, d_rdata});
    end
    @(negedge clk);
    rst_n = 1'b1;
    rst0_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({m_en, m_addr, d_ack, p_stall, m0_en, p0_stall} !== '0) begin
      n_err++;
      $display("FAIL idle_after_reset: got %h expected 0", {m_en, m_addr, d_ack, p_stall, m0_en, p0_stall});
    end
  endtask

  task automatic test_preload;
    logic [7:0]  addrs [3] = '{8'h10, 8'h80, 8'h90};
    logic [31:0] datas [3] = '{32'hE3A01005, 32'h11111111, 32'h22222222};
    int cyc;
    logic [31:0] rd;
    for (int i = 0; i < 3; i++) begin
      ref_write(2'b10, addrs[i], datas[i]);
      dbg_go(1'b1, 2'b10, addrs[i], datas[i], cyc, rd);
      n_cmp++;
      if (cyc !== 3) begin
        n_err++;
        $display("FAIL preload_ack_cycle[%0d]: got %0d expected 3", i, cyc);
      end
    end
  endtask

  task automatic test_pipe_read_word;
    logic [3:0] en_v, st_v;
    logic [31:0] rd;
    exp_q.push_back(ref_read(2'b10, 8'h10));
    @(posedge clk); #1;
    p_req = 1'b1; p_rw = 1'b0; p_size = 2'b10; p_addr = 8'h10; p_wdata = '0;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      en_v[c] = m_en;
      st_v[c] = p_stall;
      if (c == 3) rd = p_rdata;
    end
    @(posedge clk); #1;
    p_req = 1'b0;
    n_cmp++;
    if (en_v !== 4'b0100) begin
      n_err++;
      $display("FAIL read_enable_timing: got %b expected 0100", en_v);
    end
    n_cmp++;
    if (st_v !== 4'b0111) begin
      n_err++;
      $display("FAIL read_stall_timing: got %b expected 0111", st_v);
    end
    n_cmp++;
    if (rd !== exp_q.pop_front()) begin
      n_err++;
      $display("FAIL read_word_data: got %h expected e3a01005", rd);
    end
  endtask

  task automatic test_pipe_write_byte;
    int e0, stalls;
    logic [10:0] seen;
    logic [31:0] rd;
    e0 = en_cnt;
    seen = '0;
    ref_write(2'b00, 8'h21, 32'h123456AB);
    @(posedge clk); #1;
    p_req = 1'b1; p_rw = 1'b1; p_size = 2'b00; p_addr = 8'h21; p_wdata = 32'h123456AB;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (m_en) seen = {m_rw, m_size, m_addr};
      if (!p_stall) break;
    end
    @(posedge clk); #1;
    p_req = 1'b0;
    n_cmp++;
    if (en_cnt - e0 !== 1) begin
      n_err++;
      $display("FAIL write_pulse_count: got %0d expected 1", en_cnt - e0);
    end
    n_cmp++;
    if (seen !== {1'b1, 2'b00, 8'h21}) begin
      n_err++;
      $display("FAIL write_bus: got %h expected %h", seen, {1'b1, 2'b00, 8'h21});
    end
    exp_q.push_back(ref_read(2'b00, 8'h21));
    pipe_go(1'b0, 2'b00, 8'h21, '0, stalls, rd);
    n_cmp++;
    if (rd !== exp_q.pop_front()) begin
      n_err++;
      $display("FAIL write_readback: got %h expected 000000ab", rd);
    end
    n_cmp++;
    if (stalls !== 3) begin
      n_err++;
      $display("FAIL readback_stalls: got %0d expected 3", stalls);
    end
  endtask

  task automatic test_fairness;
    logic [9:0] seq;
    int n, acks;
    seq = '0;
    n = 0;
    acks = 0;
    @(posedge clk); #1;
    p_req = 1'b1; p_rw = 1'b0; p_size = 2'b10; p_addr = 8'h80;
    d_req = 1'b1; d_rw = 1'b0; d_size = 2'b10; d_addr = 8'h90;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (d_ack) begin
        acks++;
        n_cmp++;
        if (d_rdata !== ref_read(2'b10, 8'h90)) begin
          n_err++;
          $display("FAIL fair_dbg_rdata: got %h expected %h", d_rdata, ref_read(2'b10, 8'h90));
        end
      end
      if (m_en) begin
        seq = {seq[8:0], m_addr == 8'h90};
        n++;
        if (n == 10) break;
      end
    end
    @(posedge clk); #1;
    p_req = 1'b0;
    d_req = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (d_ack) acks++;
    end
    n_cmp++;
    if (seq !== 10'b0000100001) begin
      n_err++;
      $display("FAIL grant_order: got %b expected 0000100001 (1=dbg, oldest first)", seq);
    end
    n_cmp++;
    if (acks !== 2) begin
      n_err++;
      $display("FAIL fair_ack_count: got %0d expected 2", acks);
    end
  endtask

  task automatic test_dbg_write;
    logic [5:0] ack_v;
    logic [8:0] st_v;
    logic stall_any;
    logic [31:0] d_rd, p_rd;
    stall_any = 1'b0;
    ref_write(2'b10, 8'h40, 32'h00000005);
    @(posedge clk); #1;
    d_req = 1'b1; d_rw = 1'b1; d_size = 2'b10; d_addr = 8'h40; d_wdata = 32'h00000005;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      ack_v[c] = d_ack;
      stall_any |= p_stall;
      @(posedge clk); #1;
      if (ack_v[c]) d_req = 1'b0;
    end
    n_cmp++;
    if (ack_v !== 6'b001000) begin
      n_err++;
      $display("FAIL dbg_ack_timing: got %b expected 001000", ack_v);
    end
    n_cmp++;
    if (stall_any !== 1'b0) begin
      n_err++;
      $display("FAIL dbg_stall_idle: got %b expected 0", stall_any);
    end
    n_cmp++;
    if ({ram[8'h43], ram[8'h42], ram[8'h41], ram[8'h40]} !== ref_read(2'b10, 8'h40)) begin
      n_err++;
      $display("FAIL dbg_write_ram: got %h expected 00000005", {ram[8'h43], ram[8'h42], ram[8'h41], ram[8'h40]});
    end
    // Debug read in flight, pipeline request arrives one cycle later
    exp_q.push_back(ref_read(2'b10, 8'h40));
    exp_q.push_back(ref_read(2'b10, 8'h10));
    d_rd = '0;
    p_rd = '0;
    @(posedge clk); #1;
    d_req = 1'b1; d_rw = 1'b0; d_size = 2'b10; d_addr = 8'h40;
    for (int c = 0; c < 9; c++) begin
      @(negedge clk);
      st_v[c] = p_stall;
      if (d_ack) d_rd = d_rdata;
      if (p_req && !p_stall) p_rd = p_rdata;
      @(posedge clk); #1;
      if (d_ack) d_req = 1'b0;
      if (c == 0) begin
        p_req = 1'b1; p_rw = 1'b0; p_size = 2'b10; p_addr = 8'h10;
      end else if (!st_v[c]) begin
        p_req = 1'b0;
      end
    end
    n_cmp++;
    if (st_v !== 9'b001111110) begin
      n_err++;
      $display("FAIL mid_dbg_stall: got %b expected 001111110", st_v);
    end
    n_cmp++;
    if (d_rd !== exp_q.pop_front()) begin
      n_err++;
      $display("FAIL mid_dbg_rdata: got %h expected 00000005", d_rd);
    end
    n_cmp++;
    if (p_rd !== exp_q.pop_front()) begin
      n_err++;
      $display("FAIL mid_pipe_rdata: got %h expected e3a01005", p_rd);
    end
  endtask

  task automatic test_reset_abort;
    int e0, stalls;
    logic [31:0] rd;
    e0 = en_cnt;
    @(posedge clk); #1;
    p_req = 1'b1; p_rw = 1'b1; p_size = 2'b00; p_addr = 8'h21; p_wdata = 32'h0000005A;
    @(posedge clk); #3;
    rst_n = 1'b0;
    p_req = 1'b0;
    #1;
    n_cmp++;
    if ({m_en, m_rw, m_size, m_addr, m_wdata, d_ack, p_stall, p_rdata, d_rdata} !== '0) begin
      n_err++;
      $display("FAIL abort_outputs: got %h expected 0", {m_en, m_rw, m_size, m_addr, m_wdata, d_ack, p_stall, p_rdata, d_rdata});
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    n_cmp++;
    if (en_cnt !== e0) begin
      n_err++;
      $display("FAIL abort_no_strobe: got %0d pulses expected 0", en_cnt - e0);
    end
    n_cmp++;
    if (ram[8'h21] !== ref_mem[8'h21]) begin
      n_err++;
      $display("FAIL abort_ram_kept: got %h expected %h", ram[8'h21], ref_mem[8'h21]);
    end
    exp_q.push_back(ref_read(2'b00, 8'h21));
    pipe_go(1'b0, 2'b00, 8'h21, '0, stalls, rd);
    n_cmp++;
    if ({stalls, rd} !== {32'd3, exp_q.pop_front()}) begin
      n_err++;
      $display("FAIL post_abort_read: got stalls=%0d data=%h expected stalls=3 data=000000ab", stalls, rd);
    end
  endtask

  task automatic test_back_to_back;
    logic [7:0]  addrs [3] = '{8'h10, 8'h14, 8'h18};
    logic [31:0] datas [3] = '{32'hA1A2A3A4, 32'hB1B2B3B4, 32'hC1C2C3C4};
    int cyc, k, stalls, e0;
    for (int i = 0; i < 3; i++) begin
      ref_write(2'b10, addrs[i], datas[i]);
      dbg0_go(addrs[i], datas[i], cyc);
      n_cmp++;
      if (cyc !== 2) begin
        n_err++;
        $display("FAIL w0_preload_ack[%0d]: got %0d expected 2", i, cyc);
      end
      exp_q.push_back(ref_read(2'b10, addrs[i]));
    end
    e0 = en0_cnt;
    k = 0;
    stalls = 0;
    @(posedge clk); #1;
    p0_req = 1'b1; p0_rw = 1'b0; p0_size = 2'b10; p0_addr = addrs[0];
    for (int i = 0; i < 30 && k < 3; i++) begin
      @(negedge clk);
      if (p0_stall) stalls++;
      else begin
        n_cmp++;
        if ({stalls, p0_rdata} !== {32'd2, exp_q.pop_front()}) begin
          n_err++;
          $display("FAIL b2b[%0d]: got stalls=%0d data=%h expected stalls=2 data=%h", k, stalls, p0_rdata, datas[k]);
        end
        stalls = 0;
        k++;
      end
      @(posedge clk); #1;
      if (k == 3) p0_req = 1'b0;
      else p0_addr = addrs[k];
    end
    p0_req = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({k, en0_cnt - e0} !== {32'd3, 32'd3}) begin
      n_err++;
      $display("FAIL b2b_count: got done=%0d pulses=%0d expected 3/3", k, en0_cnt - e0);
    end
  endtask

  initial begin
    test_reset();
    test_preload();
    test_pipe_read_word();
    test_pipe_write_byte();
    test_fairness();
    test_dbg_write();
    test_reset_abort();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, expected finish", $time);
    $fatal(1);
  end

endmodule
